// File: rtl/baud_generator_frac.sv
// Purpose: fractional-N prescaler giving an oversampling tick plus TX bit and RX mid-bit phase ticks.
// Latency: all ticks are registered; a tick appears the cycle after the edge on which the prescaler wraps.
// Backpressure: none; ticks are free-running pulses, re-aligned only by tx_sync / rx_sync.
module baud_generator_frac #(
  parameter int DIV_WIDTH     = 16,
  parameter int FRAC_WIDTH    = 4,
  parameter int SAMPLING_RATE = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  div_load,
  input  logic                  tx_sync,
  input  logic                  rx_sync,
  output logic                  sample_tick,
  output logic                  tx_tick,
  output logic                  rx_tick,
  output logic                  div_err
);

  localparam int CW   = DIV_WIDTH + 1;
  localparam int OS_W = $clog2(SAMPLING_RATE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(SAMPLING_RATE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(SAMPLING_RATE / 2 - 1);

  logic [DIV_WIDTH-1:0]  act_int, pend_int, int_nxt;
  logic [FRAC_WIDTH-1:0] act_frac, pend_frac, acc;
  logic                  pending;
  logic [CW-1:0]         cnt, period;
  logic [OS_W-1:0]       tx_os, rx_os;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  run, tick_edge, apply;

  // Wrap detection, divisor apply point and fractional accumulator sum.
  always_comb begin
    run       = enable && !div_err;
    tick_edge = run && (cnt == period - CW'(1));
    // While stopped or stalled on an illegal divisor there is no tick to wait for,
    // so a pending divisor goes live immediately.
    apply     = pending && (!enable || div_err || tick_edge);
    acc_sum   = {1'b0, acc} + {1'b0, act_frac};
    int_nxt   = apply ? pend_int : act_int;
  end

  // Shadow/active divisor registers and the registered illegal-divisor flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_int   <= '1;
      act_frac  <= '0;
      pend_int  <= '0;
      pend_frac <= '0;
      pending   <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      if (div_load) begin
        pend_int  <= div_int;
        pend_frac <= div_frac;
      end
      if (div_load) begin
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
      if (apply) begin
        act_int  <= pend_int;
        act_frac <= pend_frac;
      end
      div_err <= (int_nxt < DIV_WIDTH'(2));
    end
  end

  // Prescaler: cycle counter, fractional accumulator and the length of the current period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc    <= '0;
      period <= {1'b0, {DIV_WIDTH{1'b1}}};
    end else if (!enable) begin
      cnt    <= '0;
      acc    <= '0;
      period <= {1'b0, int_nxt};
    end else begin
      if (!run || tx_sync || tick_edge) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (apply) begin
        acc    <= '0;
        period <= {1'b0, pend_int};
      end else if (tx_sync) begin
        acc    <= '0;
        period <= {1'b0, act_int};
      end else if (tick_edge) begin
        acc    <= acc_sum[FRAC_WIDTH-1:0];
        period <= {1'b0, act_int} + CW'(acc_sum[FRAC_WIDTH]);
      end
    end
  end

  // TX/RX phase counters and the registered tick outputs; a sync suppresses its own tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_os       <= '0;
      rx_os       <= '0;
      sample_tick <= 1'b0;
      tx_tick     <= 1'b0;
      rx_tick     <= 1'b0;
    end else if (!enable) begin
      tx_os       <= '0;
      rx_os       <= '0;
      sample_tick <= 1'b0;
      tx_tick     <= 1'b0;
      rx_tick     <= 1'b0;
    end else begin
      sample_tick <= tick_edge;
      tx_tick     <= tick_edge && !tx_sync && (tx_os == OS_LAST);
      rx_tick     <= tick_edge && !rx_sync && (rx_os == OS_MID);
      if (tx_sync) begin
        tx_os <= '0;
      end else if (tick_edge) begin
        tx_os <= (tx_os == OS_LAST) ? '0 : tx_os + OS_W'(1);
      end
      if (rx_sync) begin
        rx_os <= '0;
      end else if (tick_edge) begin
        rx_os <= (rx_os == OS_LAST) ? '0 : rx_os + OS_W'(1);
      end
    end
  end

endmodule
